// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: pipeline result, multi-cycle result handshake,
// hazard query/response, stall and register-bank write port.
// slave = arbiter view, master = driver (pipeline / bench) view.
interface writeback_arbiter_if;
    logic        pipe_valid_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        mc_valid_i;
    logic        mc_ready_o;
    logic [4:0]  mc_rd_i;
    logic [31:0] mc_data_i;
    logic [4:0]  query_rs1_i;
    logic [4:0]  query_rs2_i;
    logic        hazard_rs1_o;
    logic        hazard_rs2_o;
    logic        stall_o;
    logic        enable_o;
    logic [4:0]  rd_o;
    logic [31:0] data_o;

    modport slave (
        input  pipe_valid_i, pipe_rd_i, pipe_data_i,
        input  mc_valid_i, mc_rd_i, mc_data_i,
        input  query_rs1_i, query_rs2_i,
        output mc_ready_o, hazard_rs1_o, hazard_rs2_o, stall_o,
        output enable_o, rd_o, data_o
    );

    modport master (
        output pipe_valid_i, pipe_rd_i, pipe_data_i,
        output mc_valid_i, mc_rd_i, mc_data_i,
        output query_rs1_i, query_rs2_i,
        input  mc_ready_o, hazard_rs1_o, hazard_rs2_o, stall_o,
        input  enable_o, rd_o, data_o
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Purpose: merge pipeline and buffered multi-cycle results onto one register-bank write port.
// Latency: pipeline result 1 cycle; multi-cycle result >= 2 cycles after accept (FIFO + output reg).
// Backpressure: mc_ready_o = FIFO not full; stall_o asks the pipeline to yield after STARVE_MAX starved cycles.
// Ports: clk, reset_n (async active-low), wb (writeback_arbiter_if.slave) carrying pipe_*, mc_*,
//        query/hazard, stall_o and the enable_o/rd_o/data_o write port.
module writeback_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    writeback_arbiter_if.slave   wb
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_MAX + 1);

    // Result buffer; entry valid bits are cleared by kills and on pop so that
    // only live, not-overwritten entries feed the hazard check.
    logic [4:0]       r_ent_rd   [DEPTH];
    logic [31:0]      r_ent_data [DEPTH];
    logic [DEPTH-1:0] r_ent_vld;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;

    logic [CW-1:0]    r_starve;
    logic             r_stall;
    logic             r_en;
    logic [4:0]       r_rd;
    logic [31:0]      r_data;

    logic             w_pipe_wr;
    logic             w_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_push_vld;
    logic             w_pop;
    logic [CW-1:0]    w_starve_nxt;
    logic             w_hit1;
    logic             w_hit2;

    assign w_pipe_wr = wb.pipe_valid_i && (wb.pipe_rd_i != 5'd0);
    assign w_empty   = (r_count == '0);
    assign w_ready   = (r_count < (PW+1)'(DEPTH));
    assign w_push    = wb.mc_valid_i && w_ready;
    // Pop only when the pipeline leaves the port free; a same-cycle push into an
    // empty FIFO is not visible to the pop decision.
    assign w_pop     = !w_pipe_wr && !w_empty;
    // A same-cycle pipeline write to the same register is younger, so the
    // multi-cycle result is dead on arrival; x0 is never written.
    assign w_push_vld = (wb.mc_rd_i != 5'd0) &&
                        !(wb.pipe_valid_i && (wb.pipe_rd_i == wb.mc_rd_i));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ent_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent_rd[i]   <= '0;
                r_ent_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pipe_wr && (r_ent_rd[i] == wb.pipe_rd_i))
                    r_ent_vld[i] <= 1'b0;
            end
            if (w_pop) begin
                r_ent_vld[r_rptr] <= 1'b0;
                r_rptr            <= r_rptr + 1'b1;
            end
            // Push slot is never a live entry (count < DEPTH), so it cannot
            // collide with the kill or pop updates above.
            if (w_push) begin
                r_ent_rd[r_wptr]   <= wb.mc_rd_i;
                r_ent_data[r_wptr] <= wb.mc_data_i;
                r_ent_vld[r_wptr]  <= w_push_vld;
                r_wptr             <= r_wptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_pop)
            w_starve_nxt = '0;
        else if (r_starve < CW'(STARVE_MAX))
            w_starve_nxt = r_starve + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_en     <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
        end else begin
            r_starve <= w_starve_nxt;
            // Stall tracks the saturated counter, so it drops on the pop edge.
            r_stall  <= (w_starve_nxt == CW'(STARVE_MAX));
            if (w_pipe_wr) begin
                r_en   <= 1'b1;
                r_rd   <= wb.pipe_rd_i;
                r_data <= wb.pipe_data_i;
            end else if (w_pop) begin
                r_en   <= r_ent_vld[r_rptr];
                r_rd   <= r_ent_rd[r_rptr];
                r_data <= r_ent_data[r_rptr];
            end else begin
                r_en   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_hit1 = r_en && (r_rd == wb.query_rs1_i);
        w_hit2 = r_en && (r_rd == wb.query_rs2_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ent_vld[i] && (r_ent_rd[i] == wb.query_rs1_i)) w_hit1 = 1'b1;
            if (r_ent_vld[i] && (r_ent_rd[i] == wb.query_rs2_i)) w_hit2 = 1'b1;
        end
    end

    assign wb.mc_ready_o   = w_ready;
    assign wb.hazard_rs1_o = (wb.query_rs1_i != 5'd0) && w_hit1;
    assign wb.hazard_rs2_o = (wb.query_rs2_i != 5'd0) && w_hit2;
    assign wb.stall_o      = r_stall;
    assign wb.enable_o     = r_en;
    assign wb.rd_o         = r_rd;
    assign wb.data_o       = r_data;
endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic reset_n;
    writeback_arbiter_if bus ();

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          v;
    } ent_t;

    ent_t        fq[$];
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_starve;
    logic        m_stall;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hazard(input logic [4:0] q);
        logic hit;
        hit = m_en && (m_rd == q);
        foreach (fq[i]) if (fq[i].v && fq[i].rd == q) hit = 1'b1;
        return (q != 5'd0) && hit;
    endfunction

    task automatic model_reset();
        fq.delete();
        m_en = 1'b0; m_rd = '0; m_data = '0; m_starve = 0; m_stall = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".enable"}, {31'd0, bus.enable_o}, {31'd0, m_en});
        chk({tag, ".rd"},     {27'd0, bus.rd_o},     {27'd0, m_rd});
        chk({tag, ".data"},   bus.data_o,            m_data);
        chk({tag, ".stall"},  {31'd0, bus.stall_o},  {31'd0, m_stall});
        chk({tag, ".ready"},  {31'd0, bus.mc_ready_o}, {31'd0, fq.size() < DEPTH});
        chk({tag, ".hz1"},    {31'd0, bus.hazard_rs1_o}, {31'd0, m_hazard(bus.query_rs1_i)});
        chk({tag, ".hz2"},    {31'd0, bus.hazard_rs2_o}, {31'd0, m_hazard(bus.query_rs2_i)});
    endtask

    // One clock: drive inputs, advance the reference model across the edge, check.
    task automatic step(input string tag,
                        input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        int   sz;
        bit   pw, push, pop;
        ent_t h, n;
        bus.pipe_valid_i = pv; bus.pipe_rd_i = prd; bus.pipe_data_i = pdat;
        bus.mc_valid_i   = mv; bus.mc_rd_i   = mrd; bus.mc_data_i   = mdat;
        @(posedge clk);
        sz   = fq.size();
        pw   = pv && (prd != 0);
        push = mv && (sz < DEPTH);
        pop  = !pw && (sz > 0);
        if (pw) begin
            m_en = 1'b1; m_rd = prd; m_data = pdat;
        end else if (pop) begin
            h = fq.pop_front();
            m_en = h.v; m_rd = h.rd; m_data = h.data;
        end else begin
            m_en = 1'b0;
        end
        if (pw) foreach (fq[i]) if (fq[i].rd == prd) fq[i].v = 1'b0;
        if (push) begin
            n.rd = mrd; n.data = mdat;
            n.v  = (mrd != 0) && !(pv && prd == mrd);
            fq.push_back(n);
        end
        if (sz == 0 || pop) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
        m_stall = (m_starve == STARVE_MAX);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.pipe_valid_i = 0; bus.pipe_rd_i = 0; bus.pipe_data_i = 0;
        bus.mc_valid_i = 0; bus.mc_rd_i = 0; bus.mc_data_i = 0;
        bus.query_rs1_i = 0; bus.query_rs2_i = 0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Pipeline-only writes, then x0 ignored.
        step("pipe5", 1, 5'd5, 32'h11111111, 0, 0, 0);
        chk("pipe5.rd_const", {27'd0, bus.rd_o}, 32'd5);
        step("pipe6", 1, 5'd6, 32'h22222222, 0, 0, 0);
        chk("pipe6.data_const", bus.data_o, 32'h22222222);
        step("pipe0", 1, 5'd0, 32'h33333333, 0, 0, 0);
        chk("pipe0.en_const", {31'd0, bus.enable_o}, 32'd0);

        // Buffered write with idle pipe: visible two cycles after accept.
        step("mc7.acc", 0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
        idle("mc7.pop");
        chk("mc7.data_const", bus.data_o, 32'hDEADBEEF);
        idle("mc7.after");

        // Fill while the pipe holds the port, then one pop frees a slot.
        step("fill1", 1, 5'd1, 32'h1, 1, 5'd8,  32'h88);
        step("fill2", 1, 5'd2, 32'h2, 1, 5'd10, 32'hAA);
        chk("full.ready_const", {31'd0, bus.mc_ready_o}, 32'd0);
        step("fill3", 1, 5'd3, 32'h3, 1, 5'd11, 32'hBB);
        idle("drain1");
        chk("drain1.ready_const", {31'd0, bus.mc_ready_o}, 32'd1);
        idle("drain2");
        idle("drain3");

        // Kill of a buffered x9, then same-cycle drop.
        step("kill.buf", 1, 5'd1, 32'h1, 1, 5'd9, 32'hAA);
        step("kill.pipe", 1, 5'd9, 32'h5, 0, 0, 0);
        idle("kill.pop");
        chk("kill.pop_en_const", {31'd0, bus.enable_o}, 32'd0);
        step("drop", 1, 5'd9, 32'h6, 1, 5'd9, 32'h77);
        idle("drop.pop");
        chk("drop.pop_en_const", {31'd0, bus.enable_o}, 32'd0);
        idle("drop.after");

        // Starvation: pipe hogs the port while x3 waits.
        step("starve.buf", 1, 5'd1, 32'h1, 1, 5'd3, 32'h333);
        for (int i = 0; i < STARVE_MAX; i++)
            step("starve.hog", 1, 5'(i + 2), 32'(i), 0, 0, 0);
        chk("starve.stall_const", {31'd0, bus.stall_o}, 32'd1);
        step("starve.hog_more", 1, 5'd20, 32'h20, 0, 0, 0);
        idle("starve.release");
        chk("starve.rd_const", {27'd0, bus.rd_o}, 32'd3);
        chk("starve.clear_const", {31'd0, bus.stall_o}, 32'd0);

        // Hazards on a buffered, then output-register, x12.
        bus.query_rs1_i = 5'd12; bus.query_rs2_i = 5'd13;
        step("hz.buf", 1, 5'd1, 32'h1, 1, 5'd12, 32'hC);
        chk("hz.buf_const", {31'd0, bus.hazard_rs1_o}, 32'd1);
        idle("hz.outreg");
        chk("hz.outreg_const", {31'd0, bus.hazard_rs1_o}, 32'd1);
        idle("hz.done");
        chk("hz.done_const", {31'd0, bus.hazard_rs1_o}, 32'd0);
        bus.query_rs1_i = 5'd0; bus.query_rs2_i = 5'd0;
        #1;
        check_all("hz.zero");

        // Randomized traffic with colliding register indices.
        for (int i = 0; i < 400; i++) begin
            bus.query_rs1_i = 5'($urandom_range(0, 15));
            bus.query_rs2_i = 5'($urandom_range(0, 15));
            step("rand",
                 1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)),     5'($urandom_range(0, 15)), $urandom);
        end
        for (int i = 0; i < 4; i++) idle("rand.drain");

        // Reset with two entries buffered.
        step("rst.buf1", 1, 5'd1, 32'h1, 1, 5'd14, 32'hE1);
        step("rst.buf2", 1, 5'd2, 32'h2, 1, 5'd15, 32'hF1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("rst.mid");
        #3;
        reset_n = 1'b1;
        idle("rst.after1");
        idle("rst.after2");
        idle("rst.after3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
